// File: rtl/div_fre_pkg.sv
// rtl/div_fre_pkg.sv - shared constants for the scan-clock divider and seven-segment decoder
package div_fre_pkg;

  localparam int DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int DEF_OUT_FREQ_HZ = 1_000;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-low glyphs {g,f,e,d,c,b,a} for 0..9, A, b, C, d, E, F
  localparam logic [6:0] SSEG_LUT [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/div_fre_sseg_if.sv
// rtl/div_fre_sseg_if.sv - display bus: nibble in, segments and scan clock out; tick1k under DIV_FRE_TICK_EN
interface div_fre_sseg_if;

  logic [3:0] num;
  logic [6:0] sseg;
  logic       clk1kHz;
`ifdef DIV_FRE_TICK_EN
  logic       tick1k;
`endif

  modport slave (
    input  num,
`ifdef DIV_FRE_TICK_EN
    output tick1k,
`endif
    output sseg,
    output clk1kHz
  );

  modport master (
    output num,
`ifdef DIV_FRE_TICK_EN
    input  tick1k,
`endif
    input  sseg,
    input  clk1kHz
  );

endinterface

// File: rtl/div_fre_sseg_decoder.sv
// rtl/div_fre_sseg_decoder.sv - combinational hex nibble to active-low seven-segment decoder
module sseg_decoder
  import div_fre_pkg::*;
(
  input  logic [3:0] num,
  output logic [6:0] sseg
);

  logic [6:0] glyph;

  assign glyph = SSEG_LUT[num];
  assign sseg  = {glyph[SEG_G], glyph[SEG_F], glyph[SEG_E], glyph[SEG_D],
                  glyph[SEG_C], glyph[SEG_B], glyph[SEG_A]};

endmodule

// File: rtl/div_fre_sseg.sv
// rtl/div_fre_sseg.sv - 50% duty scan-clock divider plus segment decoder; DIV_FRE_TICK_EN adds tick1k strobe
module div_fre_sseg
  import div_fre_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int OUT_FREQ_HZ = DEF_OUT_FREQ_HZ
) (
  input  logic           clk,
  input  logic           rst_n,
  div_fre_sseg_if.slave  bus
);

  localparam int HALF = CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  if (HALF < 1) begin : g_half_check
    $error("div_fre_sseg: CLK_FREQ_HZ / (2*OUT_FREQ_HZ) must be at least 1");
  end

  logic [CW-1:0] cnt;
  logic          clk_q;
  logic          wrap;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      clk_q <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      clk_q <= ~clk_q;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  assign bus.clk1kHz = clk_q;

`ifdef DIV_FRE_TICK_EN
  logic tick_q;

  // Fires on the wrap that turns the output high, so it lands in its first high cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap & ~clk_q;
    end
  end

  assign bus.tick1k = tick_q;
`endif

  sseg_decoder u_decoder (
    .num  (bus.num),
    .sseg (bus.sseg)
  );

endmodule

// File: tb/tb_div_fre_sseg.sv
// tb/tb_div_fre_sseg.sv - directed bench for div_fre_sseg at HALF = 100, 4 and 1
module tb_div_fre_sseg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  div_fre_sseg_if if_mid ();
  div_fre_sseg_if if_h4 ();
  div_fre_sseg_if if_h1 ();

  div_fre_sseg #(.CLK_FREQ_HZ(2000), .OUT_FREQ_HZ(10)) u_mid (.clk(clk), .rst_n(rst_n), .bus(if_mid));
  div_fre_sseg #(.CLK_FREQ_HZ(8),    .OUT_FREQ_HZ(1))  u_h4  (.clk(clk), .rst_n(rst_n), .bus(if_h4));
  div_fre_sseg #(.CLK_FREQ_HZ(2),    .OUT_FREQ_HZ(1))  u_h1  (.clk(clk), .rst_n(rst_n), .bus(if_h1));

  logic [6:0] exp_seg [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Edge k counts rising clk edges since reset release; k = HALF is the first high sample
  task automatic run_edges(input int first, input int n, input string ph);
    for (int k = first; k < first + n; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_mid_k%0d", ph, k), if_mid.clk1kHz, (k / 100) % 2);
      check($sformatf("%s_h4_k%0d", ph, k), if_h4.clk1kHz, (k / 4) % 2);
      check($sformatf("%s_h1_k%0d", ph, k), if_h1.clk1kHz, k % 2);
`ifdef DIV_FRE_TICK_EN
      check($sformatf("%s_tmid_k%0d", ph, k), if_mid.tick1k, (k % 200) == 100);
      check($sformatf("%s_th4_k%0d", ph, k), if_h4.tick1k, (k % 8) == 4);
      check($sformatf("%s_th1_k%0d", ph, k), if_h1.tick1k, k % 2);
`endif
      if_h1.num = (k % 2 == 1) ? 4'hA : 4'hB;
      #1;
      check($sformatf("%s_seg_k%0d", ph, k), if_h1.sseg, (k % 2 == 1) ? 7'h08 : 7'h03);
    end
  endtask

  task automatic check_reset_state(input string ph);
    check({ph, "_mid"}, if_mid.clk1kHz, 0);
    check({ph, "_h4"}, if_h4.clk1kHz, 0);
    check({ph, "_h1"}, if_h1.clk1kHz, 0);
`ifdef DIV_FRE_TICK_EN
    check({ph, "_tmid"}, if_mid.tick1k, 0);
    check({ph, "_th4"}, if_h4.tick1k, 0);
    check({ph, "_th1"}, if_h1.tick1k, 0);
`endif
  endtask

  initial begin
    if_mid.num = 4'h0;
    if_h4.num  = 4'h0;
    if_h1.num  = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");

    for (int i = 0; i < 16; i++) begin
      if_mid.num = 4'(i);
      #1;
      check($sformatf("seg_%0h", i), if_mid.sseg, exp_seg[i]);
    end

    @(negedge clk);
    rst_n = 1'b1;
    run_edges(1, 1160, "run");
    check("pre_rst_high", if_mid.clk1kHz, 1);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_mid", if_mid.clk1kHz, 0);
    check("async_h1_seg", if_h1.sseg, 7'h03);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("hold");
    if_h1.num = 4'hA;
    #1;
    check("hold_seg", if_h1.sseg, 7'h08);

    @(negedge clk);
    rst_n = 1'b1;
    run_edges(1, 210, "rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
